// File: rtl/cond_eval_unit.sv
// Multi-lane ARM condition evaluator with owned NZCV register and LIFO checkpoint stack.
// Optional per-lane pass counters are enabled with `define COND_STATS_EN.
module cond_eval_unit #(
    parameter int LANES = 2,
    parameter int PIPE  = 1,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sr_we,
    input  logic [3:0]           sr_in,
    input  logic                 ckpt_push,
    input  logic                 ckpt_pop,
    input  logic [LANES-1:0]     cond_valid,
    input  logic [4*LANES-1:0]   cond,
    output logic [LANES-1:0]     res_valid,
    output logic [LANES-1:0]     cond_res,
    output logic [3:0]           status,
    output logic                 stk_full,
    output logic                 stk_empty,
`ifdef COND_STATS_EN
    input  logic                 stat_clr,
    output logic [16*LANES-1:0]  stat_pass,
`endif
    output logic                 stk_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Evaluate one ARM condition code against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        case (cc)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]    status_q, status_d;
    logic [3:0]    stk_q [DEPTH];
    logic [3:0]    stk_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          full_s, empty_s, pop_ok_s, push_ok_s;
    logic [IW-1:0] top_idx_s;
    logic [LANES-1:0] pass_s;

    assign full_s    = (cnt_q == FULL_CNT);
    assign empty_s   = (cnt_q == {CW{1'b0}});
    assign stk_full  = full_s;
    assign stk_empty = empty_s;
    assign stk_err   = err_q;
    assign status    = status_q;

    // Stack, status and error next-state; status_d doubles as the bypassed evaluation flags.
    always_comb begin
        pop_ok_s  = ckpt_pop & ~empty_s;
        push_ok_s = ckpt_push & (~full_s | pop_ok_s);
        top_idx_s = IW'(cnt_q - CW'(1));
        stk_d     = stk_q;
        cnt_d     = cnt_q;
        if (push_ok_s && pop_ok_s) begin
            stk_d[top_idx_s] = status_q;
        end else if (push_ok_s) begin
            stk_d[cnt_q[IW-1:0]] = status_q;
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok_s) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (pop_ok_s) begin
            status_d = stk_q[top_idx_s];
        end else if (sr_we) begin
            status_d = sr_in;
        end else begin
            status_d = status_q;
        end
        // An empty-stack push+pop is a plain push, so it is not an underflow.
        err_d = err_q | (ckpt_push & full_s & ~pop_ok_s) | (ckpt_pop & empty_s & ~ckpt_push);
    end

    // Per-lane evaluation against the effective flags.
    always_comb begin
        pass_s = '0;
        for (int i = 0; i < LANES; i++) begin
            pass_s[i] = cond_valid[i] & cond_eval(cond[4*i +: 4], status_d);
        end
    end

    // Status register, checkpoint stack and sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= 4'b0000;
            cnt_q    <= {CW{1'b0}};
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= 4'b0000;
            end
        end else begin
            status_q <= status_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            stk_q    <= stk_d;
        end
    end

    generate
        if (PIPE == 0) begin : g_comb
            assign res_valid = cond_valid;
            assign cond_res  = pass_s;
        end else begin : g_reg
            logic [LANES-1:0] res_valid_q, cond_res_q;
            // Registered result stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    res_valid_q <= '0;
                    cond_res_q  <= '0;
                end else begin
                    res_valid_q <= cond_valid;
                    cond_res_q  <= pass_s;
                end
            end
            assign res_valid = res_valid_q;
            assign cond_res  = cond_res_q;
        end
    endgenerate

`ifdef COND_STATS_EN
    logic [15:0] stat_q [LANES];
    logic [15:0] stat_d [LANES];

    // Saturating pass counters; clear takes precedence over increment.
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < LANES; i++) begin
            if (stat_clr) begin
                stat_d[i] = 16'h0000;
            end else if (pass_s[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'h0001;
            end else begin
                stat_d[i] = stat_q[i];
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                stat_q[i] <= 16'h0000;
            end
        end else begin
            stat_q <= stat_d;
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        stat_pass = '0;
        for (int i = 0; i < LANES; i++) begin
            stat_pass[16*i +: 16] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed self-checking bench for cond_eval_unit (LANES=2, PIPE=1, DEPTH=4).
module tb_cond_eval_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sr_we, ckpt_push, ckpt_pop;
    logic [3:0] sr_in;
    logic [1:0] cond_valid;
    logic [7:0] cond;
    logic [1:0] res_valid, cond_res;
    logic [3:0] status;
    logic       stk_full, stk_empty, stk_err;

    int errors = 0;
    int checks = 0;

    cond_eval_unit #(.LANES(2), .PIPE(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in),
        .ckpt_push(ckpt_push), .ckpt_pop(ckpt_pop),
        .cond_valid(cond_valid), .cond(cond),
        .res_valid(res_valid), .cond_res(cond_res), .status(status),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sr_we = 1'b0; sr_in = 4'b0000; ckpt_push = 1'b0; ckpt_pop = 1'b0;
        cond_valid = 2'b00; cond = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        #3;
        if (status !== 4'b0000) begin $display("FAIL reset_status got=%b exp=0000", status); errors++; end checks++;
        if (stk_empty !== 1'b1) begin $display("FAIL reset_empty got=%b exp=1", stk_empty); errors++; end checks++;
        if (stk_full !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", stk_full); errors++; end checks++;
        if (stk_err !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", stk_err); errors++; end checks++;
        if (res_valid !== 2'b00) begin $display("FAIL reset_res_valid got=%b exp=00", res_valid); errors++; end checks++;
        if (cond_res !== 2'b00) begin $display("FAIL reset_cond_res got=%b exp=00", cond_res); errors++; end checks++;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        sr_we = 1'b1; sr_in = 4'b0100;
        cyc();
        idle();
        cond_valid = 2'b11; cond = {4'b0001, 4'b0000};
        cyc();
        if (res_valid !== 2'b11) begin $display("FAIL basic_res_valid got=%b exp=11", res_valid); errors++; end checks++;
        if (cond_res !== 2'b01) begin $display("FAIL basic_cond_res got=%b exp=01", cond_res); errors++; end checks++;
        if (status !== 4'b0100) begin $display("FAIL basic_status got=%b exp=0100", status); errors++; end checks++;
        idle();
    endtask

    task automatic test_bypass();
        sr_we = 1'b1; sr_in = 4'b1001;
        cond_valid = 2'b01; cond = {4'b1110, 4'b1100};
        cyc();
        if (res_valid !== 2'b01) begin $display("FAIL bypass_res_valid got=%b exp=01", res_valid); errors++; end checks++;
        if (cond_res !== 2'b01) begin $display("FAIL bypass_cond_res got=%b exp=01", cond_res); errors++; end checks++;
        if (status !== 4'b1001) begin $display("FAIL bypass_status got=%b exp=1001", status); errors++; end checks++;
        idle();
    endtask

    task automatic test_table();
        sr_we = 1'b1; sr_in = 4'b1000;
        cyc();
        idle();
        cond_valid = 2'b11; cond = {4'b1010, 4'b1101};
        cyc();
        if (cond_res !== 2'b01) begin $display("FAIL table_le_ge got=%b exp=01", cond_res); errors++; end checks++;
        cond = {4'b1110, 4'b1111};
        cyc();
        if (cond_res !== 2'b10) begin $display("FAIL table_al_nv got=%b exp=10", cond_res); errors++; end checks++;
        cond_valid = 2'b01; cond = {4'b1110, 4'b1110};
        cyc();
        if (res_valid !== 2'b01) begin $display("FAIL table_masked_valid got=%b exp=01", res_valid); errors++; end checks++;
        if (cond_res !== 2'b01) begin $display("FAIL table_masked_res got=%b exp=01", cond_res); errors++; end checks++;
        idle();
    endtask

    task automatic test_push_pop_same();
        sr_we = 1'b1; sr_in = 4'b0110;
        cyc();
        idle();
        ckpt_push = 1'b1; ckpt_pop = 1'b1;
        cyc();
        if (stk_empty !== 1'b0) begin $display("FAIL pp_empty_push got=%b exp=0", stk_empty); errors++; end checks++;
        if (stk_err !== 1'b0) begin $display("FAIL pp_empty_err got=%b exp=0", stk_err); errors++; end checks++;
        idle();
        sr_we = 1'b1; sr_in = 4'b0111;
        cyc();
        idle();
        ckpt_push = 1'b1; ckpt_pop = 1'b1;
        cyc();
        if (status !== 4'b0110) begin $display("FAIL pp_restore got=%b exp=0110", status); errors++; end checks++;
        if (stk_empty !== 1'b0) begin $display("FAIL pp_count_empty got=%b exp=0", stk_empty); errors++; end checks++;
        idle();
        ckpt_pop = 1'b1;
        cyc();
        if (status !== 4'b0111) begin $display("FAIL pp_overwrite got=%b exp=0111", status); errors++; end checks++;
        if (stk_empty !== 1'b1) begin $display("FAIL pp_final_empty got=%b exp=1", stk_empty); errors++; end checks++;
        idle();
    endtask

    task automatic test_ckpt();
        sr_we = 1'b1; sr_in = 4'b0010;
        cyc();
        idle();
        ckpt_push = 1'b1;
        cyc();
        idle();
        sr_we = 1'b1; sr_in = 4'b1000;
        cyc();
        if (status !== 4'b1000) begin $display("FAIL ckpt_mid_status got=%b exp=1000", status); errors++; end checks++;
        idle();
        ckpt_pop = 1'b1; sr_we = 1'b1; sr_in = 4'b1101;
        cond_valid = 2'b01; cond = {4'b0010, 4'b0010};
        cyc();
        if (status !== 4'b0010) begin $display("FAIL ckpt_restore got=%b exp=0010", status); errors++; end checks++;
        if (stk_empty !== 1'b1) begin $display("FAIL ckpt_empty got=%b exp=1", stk_empty); errors++; end checks++;
        if (stk_err !== 1'b0) begin $display("FAIL ckpt_err got=%b exp=0", stk_err); errors++; end checks++;
        if (cond_res !== 2'b01) begin $display("FAIL ckpt_pop_bypass got=%b exp=01", cond_res); errors++; end checks++;
        idle();
    endtask

    task automatic test_overflow();
        logic [3:0] exp_pop [4];
        exp_pop[0] = 4'b0100; exp_pop[1] = 4'b0011; exp_pop[2] = 4'b0010; exp_pop[3] = 4'b0001;
        sr_we = 1'b1; sr_in = 4'b0001;
        cyc();
        for (int k = 0; k < 4; k++) begin
            ckpt_push = 1'b1; sr_we = 1'b1; sr_in = 4'(k + 2);
            cyc();
            if (k == 2) begin
                if (stk_full !== 1'b0) begin $display("FAIL ovf_not_full got=%b exp=0", stk_full); errors++; end checks++;
            end
        end
        if (stk_full !== 1'b1) begin $display("FAIL ovf_full got=%b exp=1", stk_full); errors++; end checks++;
        if (stk_err !== 1'b0) begin $display("FAIL ovf_err_early got=%b exp=0", stk_err); errors++; end checks++;
        idle();
        ckpt_push = 1'b1;
        cyc();
        if (stk_err !== 1'b1) begin $display("FAIL ovf_err got=%b exp=1", stk_err); errors++; end checks++;
        if (stk_full !== 1'b1) begin $display("FAIL ovf_still_full got=%b exp=1", stk_full); errors++; end checks++;
        if (status !== 4'b0101) begin $display("FAIL ovf_status got=%b exp=0101", status); errors++; end checks++;
        idle();
        for (int k = 0; k < 4; k++) begin
            ckpt_pop = 1'b1;
            cyc();
            if (status !== exp_pop[k]) begin $display("FAIL lifo_pop%0d got=%b exp=%b", k, status, exp_pop[k]); errors++; end checks++;
        end
        if (stk_empty !== 1'b1) begin $display("FAIL lifo_empty got=%b exp=1", stk_empty); errors++; end checks++;
        cyc();
        if (status !== 4'b0001) begin $display("FAIL udf_status got=%b exp=0001", status); errors++; end checks++;
        if (stk_err !== 1'b1) begin $display("FAIL udf_err got=%b exp=1", stk_err); errors++; end checks++;
        idle();
    endtask

    task automatic test_async_reset();
        cond_valid = 2'b11; cond = {4'b1110, 4'b1110};
        cyc();
        if (res_valid !== 2'b11) begin $display("FAIL arst_pre_valid got=%b exp=11", res_valid); errors++; end checks++;
        idle();
        #2;
        rst = 1'b0;
        #1;
        if (res_valid !== 2'b00) begin $display("FAIL arst_res_valid got=%b exp=00", res_valid); errors++; end checks++;
        if (cond_res !== 2'b00) begin $display("FAIL arst_cond_res got=%b exp=00", cond_res); errors++; end checks++;
        cyc();
        rst = 1'b1;
        cyc();
        if (status !== 4'b0000) begin $display("FAIL arst_status got=%b exp=0000", status); errors++; end checks++;
        if (stk_empty !== 1'b1) begin $display("FAIL arst_empty got=%b exp=1", stk_empty); errors++; end checks++;
        if (stk_err !== 1'b0) begin $display("FAIL arst_err got=%b exp=0", stk_err); errors++; end checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_table();
        test_push_pop_same();
        test_ckpt();
        test_overflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
